sdram_vga_reader: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/sdram_vga_reader.sv | 113 +++++++++++
 tb/tb_sdram_vga_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA read path.
// Latency: n/a (package only).
// Backpressure: n/a; the display never stalls, the FIFO must keep up.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Counter-to-pin latency of every display output
  localparam int PIPE_DEPTH = 3;

  // RGB565 field positions
  localparam int R_HI = 15;
  localparam int G_HI = 10;
  localparam int B_HI = 4;

  // Timing bits that travel alongside a pixel through the pipeline
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tmg_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int span_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  // Replicate the field MSBs into the new LSBs so full-scale maps to 8'hFF
  function automatic rgb888_t rgb565_expand(input logic [15:0] d);
    rgb888_t p;
    p.r = {d[R_HI -: 5], d[R_HI -: 3]};
    p.g = {d[G_HI -: 6], d[G_HI -: 2]};
    p.b = {d[B_HI -: 5], d[B_HI -: 3]};
    return p;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with active/sync/frame-start decode.
// Latency: decodes are combinational from the registered counters (stage 0).
// Backpressure: none; counters advance every clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       act,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Raster scan: h wraps every line, v steps on each h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign act         = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs          = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs          = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  // First clock of the first VS line: far from the next active pixel,
  // which gives the SDRAM controller time to reload its read address.
  assign frame_start = (h_cnt == 10'd0) && (v_cnt == VS_FIRST);

endmodule

// File: rtl/sdram_vga_reader.sv
// Pulls one RGB565 word per visible pixel from an SDRAM read FIFO and drives VGA pins.
// Latency: 3 clocks from raster counters to every pin; FIFO read issued 1 clock after counters.
// Backpressure: none; the FIFO is read blindly (underflow undetected), frame enable latched per frame.
module sdram_vga_reader
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = 0
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iENABLE,
  input  logic [15:0] iRD_DATA,
  output logic        oRD_REQ,
  output logic        oFRAME_START,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic [9:0]  oH_CNT,
  output logic [9:0]  oV_CNT
);

  localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  logic    t_act;
  logic    t_hs;
  logic    t_vs;
  logic    en_frame;
  logic    req_s2;
  tmg_t    s1;
  tmg_t    s2;
  rgb888_t pix;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (iCLK),
    .rst_n       (iRST_N),
    .h_cnt       (oH_CNT),
    .v_cnt       (oV_CNT),
    .act         (t_act),
    .hs          (t_hs),
    .vs          (t_vs),
    .frame_start (oFRAME_START)
  );

  // Enable only changes at the frame boundary so a frame is never cut short or started late
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      en_frame <= 1'b0;
    end else if (oFRAME_START) begin
      en_frame <= iENABLE;
    end
  end

  // Stages 1-2: FIFO request plus timing bits delayed to meet the returning data
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRD_REQ <= 1'b0;
      req_s2  <= 1'b0;
      s1      <= '0;
      s2      <= '0;
    end else begin
      oRD_REQ <= t_act & en_frame;
      req_s2  <= oRD_REQ;
      s1      <= '{act: t_act, hs: t_hs, vs: t_vs};
      s2      <= s1;
    end
  end

  assign pix = rgb565_expand(iRD_DATA);

  // Stage 3: register all pins together; colour only where a word was actually requested
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_HS      <= SYNC_IDLE;
      oVGA_VS      <= SYNC_IDLE;
      oVGA_BLANK_N <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
    end else begin
      oVGA_HS      <= SYNC_IDLE ^ s2.hs;
      oVGA_VS      <= SYNC_IDLE ^ s2.vs;
      oVGA_BLANK_N <= s2.act;
      oVGA_R       <= req_s2 ? pix.r : 8'd0;
      oVGA_G       <= req_s2 ? pix.g : 8'd0;
      oVGA_B       <= req_s2 ? pix.b : 8'd0;
    end
  end

  // No sync-on-green
  assign oVGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_sdram_vga_reader.sv
// Directed bench for sdram_vga_reader on a shrunken raster:
// H = 8+2+3+2 = 15 clocks/line, V = 4+1+2+1 = 8 lines, 120 clocks/frame.
// cyc counts clock edges since reset release, so cyc equals the raster index.
module tb_sdram_vga_reader;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iENABLE = 1'b0;
  logic [15:0] iRD_DATA = 16'h0000;
  logic        oRD_REQ, oFRAME_START, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic [9:0]  oH_CNT, oV_CNT;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] fifo_word = 16'hF800;
  logic        fifo_count_mode = 1'b0;
  logic [15:0] pop_cnt = 16'h0000;

  sdram_vga_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iENABLE(iENABLE), .iRD_DATA(iRD_DATA),
    .oRD_REQ(oRD_REQ), .oFRAME_START(oFRAME_START),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oVGA_SYNC_N(oVGA_SYNC_N), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oH_CNT(oH_CNT), .oV_CNT(oV_CNT)
  );

  always #5 iCLK = ~iCLK;

  // Normal-mode FIFO: data appears the clock after a request
  always @(posedge iCLK) begin
    if (!fifo_count_mode) pop_cnt <= 16'h0000;
    else if (oRD_REQ)     pop_cnt <= pop_cnt + 16'h0001;
    if (oRD_REQ) iRD_DATA <= fifo_count_mode ? pop_cnt : fifo_word;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iENABLE = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (oH_CNT !== 10'd0) begin n_err++; $display("FAIL reset_h: got %0d want 0", oH_CNT); end
    n_cmp++; if (oV_CNT !== 10'd0) begin n_err++; $display("FAIL reset_v: got %0d want 0", oV_CNT); end
    n_cmp++; if (oRD_REQ !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", oRD_REQ); end
    n_cmp++; if (oFRAME_START !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", oFRAME_START); end
    n_cmp++; if (oVGA_BLANK_N !== 1'b0) begin n_err++; $display("FAIL reset_blank: got %b want 0", oVGA_BLANK_N); end
    n_cmp++; if ({oVGA_HS, oVGA_VS} !== 2'b11) begin n_err++; $display("FAIL reset_sync: got %b want 11", {oVGA_HS, oVGA_VS}); end
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h0) begin n_err++; $display("FAIL reset_rgb: got %h want 000000", {oVGA_R, oVGA_G, oVGA_B}); end
    n_cmp++; if (oVGA_SYNC_N !== 1'b0) begin n_err++; $display("FAIL sync_n: got %b want 0", oVGA_SYNC_N); end
    #2 iRST_N = 1'b1;
    cyc = 0;
  endtask

  task automatic test_frame_start();
    int found;
    found = -1;
    for (int i = 0; i < 200 && found < 0; i++) begin
      tick();
      if (oFRAME_START === 1'b1) found = cyc;
    end
    n_cmp++; if (found != 75) begin n_err++; $display("FAIL first_fs_cycle: got %0d want 75", found); end
    tick();
    n_cmp++; if (oFRAME_START !== 1'b0) begin n_err++; $display("FAIL fs_width: got %b want 0 at cycle 76", oFRAME_START); end
    found = -1;
    for (int i = 0; i < 100 && found < 0; i++) begin
      tick();
      if (oRD_REQ === 1'b1) found = cyc;
    end
    n_cmp++; if (found != 121) begin n_err++; $display("FAIL first_req_cycle: got %0d want 121", found); end
    n_cmp++; if ({oV_CNT, oH_CNT} !== {10'd0, 10'd1}) begin n_err++; $display("FAIL first_req_cnt: got v=%0d h=%0d want v=0 h=1", oV_CNT, oH_CNT); end
  endtask

  task automatic test_requests();
    int cnt, run, max_run, runs;
    cnt = 0; run = 0; max_run = 0; runs = 0;
    while (cyc <= 240) begin
      if (oRD_REQ === 1'b1) begin
        cnt++; run++;
        if (run == 1) runs++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
    end
    n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL req_per_frame: got %0d want 32", cnt); end
    n_cmp++; if (max_run != 8) begin n_err++; $display("FAIL req_run_len: got %0d want 8", max_run); end
    n_cmp++; if (runs != 4) begin n_err++; $display("FAIL req_runs: got %0d want 4", runs); end
  endtask

  task automatic test_rgb_expand();
    // Frame 2 (index 240): word F800 -> pure red
    run_to(243);
    n_cmp++; if ({oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B} !== {1'b1, 24'hFF0000}) begin n_err++;
      $display("FAIL red_first_px: got %b %h want 1 ff0000", oVGA_BLANK_N, {oVGA_R, oVGA_G, oVGA_B}); end
    run_to(251);
    n_cmp++; if ({oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B} !== {1'b0, 24'h000000}) begin n_err++;
      $display("FAIL hblank_px: got %b %h want 0 000000", oVGA_BLANK_N, {oVGA_R, oVGA_G, oVGA_B}); end
    run_to(295);
    n_cmp++; if ({oVGA_BLANK_N, oVGA_R} !== {1'b1, 8'hFF}) begin n_err++;
      $display("FAIL red_last_px: got %b %h want 1 ff", oVGA_BLANK_N, oVGA_R); end
    tick();
    n_cmp++; if ({oVGA_BLANK_N, oVGA_R} !== {1'b0, 8'h00}) begin n_err++;
      $display("FAIL after_last_px: got %b %h want 0 00", oVGA_BLANK_N, oVGA_R); end
    run_to(345);
    fifo_word = 16'h07E0;
    run_to(363);
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h00FF00) begin n_err++;
      $display("FAIL green_px: got %h want 00ff00", {oVGA_R, oVGA_G, oVGA_B}); end
    run_to(465);
    fifo_word = 16'h0841;
    run_to(483);
    // 0841: R=00001, G=000010, B=00001 -> 08, 08, 08
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h080808) begin n_err++;
      $display("FAIL low_px: got %h want 080808", {oVGA_R, oVGA_G, oVGA_B}); end
  endtask

  task automatic test_sync();
    int hs_low, vs_low, fs_at;
    hs_low = 0; vs_low = 0; fs_at = -1;
    // HS pin low at raster index c when (c-3) mod 15 in 10..12
    run_to(492);
    n_cmp++; if (oVGA_HS !== 1'b1) begin n_err++; $display("FAIL hs_before: got %b want 1", oVGA_HS); end
    tick();
    n_cmp++; if (oVGA_HS !== 1'b0) begin n_err++; $display("FAIL hs_fall: got %b want 0", oVGA_HS); end
    run_to(495);
    n_cmp++; if (oVGA_HS !== 1'b0) begin n_err++; $display("FAIL hs_last: got %b want 0", oVGA_HS); end
    tick();
    n_cmp++; if (oVGA_HS !== 1'b1) begin n_err++; $display("FAIL hs_rise: got %b want 1", oVGA_HS); end
    run_to(500);
    while (cyc <= 619) begin
      if (oVGA_HS === 1'b0) hs_low++;
      if (oVGA_VS === 1'b0) vs_low++;
      if (oFRAME_START === 1'b1) fs_at = cyc;
      if (cyc == 557) begin n_cmp++; if (oVGA_VS !== 1'b1) begin n_err++; $display("FAIL vs_before: got %b want 1", oVGA_VS); end end
      if (cyc == 558) begin n_cmp++; if (oVGA_VS !== 1'b0) begin n_err++; $display("FAIL vs_fall: got %b want 0", oVGA_VS); end end
      if (cyc == 588) begin n_cmp++; if (oVGA_VS !== 1'b1) begin n_err++; $display("FAIL vs_rise: got %b want 1", oVGA_VS); end end
      if (cyc == 590) fifo_count_mode = 1'b1;
      tick();
    end
    n_cmp++; if (hs_low != 24) begin n_err++; $display("FAIL hs_low_per_frame: got %0d want 24", hs_low); end
    n_cmp++; if (vs_low != 30) begin n_err++; $display("FAIL vs_low_per_frame: got %0d want 30", vs_low); end
    n_cmp++; if (fs_at != 555) begin n_err++; $display("FAIL fs_period: got %0d want 555", fs_at); end
  endtask

  task automatic test_fifo_order();
    // Frame 5 reads return 0,1,2,...: pixel (line1,h2) gets word 10, (line3,h7) word 31
    run_to(620);
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h000052) begin n_err++;
      $display("FAIL word10_px: got %h want 000052", {oVGA_R, oVGA_G, oVGA_B}); end
    run_to(655);
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h0000FF) begin n_err++;
      $display("FAIL word31_px: got %h want 0000ff", {oVGA_R, oVGA_G, oVGA_B}); end
  endtask

  task automatic test_enable();
    int req_cnt, blank_hi, rgb_nz, hs_low;
    req_cnt = 0;
    run_to(721);
    while (cyc <= 840) begin
      if (oRD_REQ === 1'b1) req_cnt++;
      if (cyc == 750) iENABLE = 1'b0;
      tick();
    end
    n_cmp++; if (req_cnt != 32) begin n_err++; $display("FAIL en_drop_same_frame: got %0d want 32", req_cnt); end
    req_cnt = 0; blank_hi = 0; rgb_nz = 0; hs_low = 0;
    while (cyc <= 960) begin
      if (oRD_REQ === 1'b1) req_cnt++;
      if (oVGA_BLANK_N === 1'b1) blank_hi++;
      if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h0) rgb_nz++;
      if (oVGA_HS === 1'b0) hs_low++;
      if (cyc == 880) iENABLE = 1'b1;
      tick();
    end
    n_cmp++; if (req_cnt != 0) begin n_err++; $display("FAIL disabled_reqs: got %0d want 0", req_cnt); end
    n_cmp++; if (blank_hi != 32) begin n_err++; $display("FAIL disabled_blank: got %0d want 32", blank_hi); end
    n_cmp++; if (rgb_nz != 0) begin n_err++; $display("FAIL disabled_rgb: got %0d want 0", rgb_nz); end
    n_cmp++; if (hs_low != 24) begin n_err++; $display("FAIL disabled_hs: got %0d want 24", hs_low); end
    req_cnt = 0;
    while (cyc <= 1080) begin
      if (oRD_REQ === 1'b1) req_cnt++;
      tick();
    end
    n_cmp++; if (req_cnt != 32) begin n_err++; $display("FAIL reenable_reqs: got %0d want 32", req_cnt); end
  endtask

  task automatic test_reset_midframe();
    int req_cnt;
    req_cnt = 0;
    // Index 1115 = frame 9, line 2, h 5: mid active video
    run_to(1115);
    n_cmp++; if ({oRD_REQ, oVGA_BLANK_N} !== 2'b11) begin n_err++; $display("FAIL pre_reset_active: got %b want 11", {oRD_REQ, oVGA_BLANK_N}); end
    #2 iRST_N = 1'b0;
    #1;
    n_cmp++; if ({oV_CNT, oH_CNT} !== 20'd0) begin n_err++; $display("FAIL async_cnt: got v=%0d h=%0d want 0 0", oV_CNT, oH_CNT); end
    n_cmp++; if ({oRD_REQ, oVGA_BLANK_N} !== 2'b00) begin n_err++; $display("FAIL async_req_blank: got %b want 00", {oRD_REQ, oVGA_BLANK_N}); end
    n_cmp++; if ({oVGA_R, oVGA_G, oVGA_B} !== 24'h0) begin n_err++; $display("FAIL async_rgb: got %h want 000000", {oVGA_R, oVGA_G, oVGA_B}); end
    tick(); tick();
    #2 iRST_N = 1'b1;
    cyc = 0;
    while (cyc < 120) begin
      tick();
      if (oRD_REQ === 1'b1) req_cnt++;
    end
    n_cmp++; if (req_cnt != 0) begin n_err++; $display("FAIL post_reset_reqs: got %0d want 0", req_cnt); end
    tick();
    n_cmp++; if (oRD_REQ !== 1'b1) begin n_err++; $display("FAIL post_reset_first_req: got %b want 1 at 121", oRD_REQ); end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_requests();
    test_rgb_expand();
    test_sync();
    test_fifo_order();
    test_enable();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
